stack_arbiter: RTL and testbench

//  Shares one 8-entry LIFO stack between two requesters, A and B.

---
 rtl/stack_arbiter.sv | 98 +++++++++
 tb/tb_stack_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin arbiter giving two req/ack clients one-at-a-time
// access to a shared LIFO stack, with full/empty rejection and pop data return.
module stack_arbiter #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_push_pop,
    input  logic [DW-1:0] a_data,
    output logic          a_ack,
    output logic          a_err,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_push_pop,
    input  logic [DW-1:0] b_data,
    output logic          b_ack,
    output logic          b_err,
    output logic [DW-1:0] b_rdata,
    output logic          stk_enable,
    output logic          stk_push_pop,
    output logic [DW-1:0] stk_data_in,
    input  logic [DW-1:0] stk_data_out,
    input  logic          stk_empty,
    input  logic          stk_full
);
    typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;
    state_t        r_state;
    logic          r_last_a;
    logic          r_win_a;
    logic          r_op;
    logic          w_win_a;
    logic          w_op;
    logic          w_err;
    logic [DW-1:0] w_data;
    // A wins unless B also requests and A was granted last
    assign w_win_a = a_req && (!b_req || !r_last_a);
    assign w_op    = w_win_a ? a_push_pop : b_push_pop;
    assign w_data  = w_win_a ? a_data : b_data;
    assign w_err   = w_op ? stk_full : stk_empty;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_a     <= 1'b0;
            r_win_a      <= 1'b0;
            r_op         <= 1'b0;
            a_ack        <= 1'b0;
            a_err        <= 1'b0;
            a_rdata      <= '0;
            b_ack        <= 1'b0;
            b_err        <= 1'b0;
            b_rdata      <= '0;
            stk_enable   <= 1'b0;
            stk_push_pop <= 1'b0;
            stk_data_in  <= '0;
        end else begin
            a_ack        <= 1'b0;
            a_err        <= 1'b0;
            b_ack        <= 1'b0;
            b_err        <= 1'b0;
            stk_enable   <= 1'b0;
            stk_push_pop <= 1'b0;
            stk_data_in  <= '0;
            case (r_state)
                IDLE: if (a_req || b_req) begin
                    r_win_a  <= w_win_a;
                    r_last_a <= w_win_a;
                    r_op     <= w_op;
                    if (w_err) begin
                        a_ack   <= w_win_a;
                        a_err   <= w_win_a;
                        b_ack   <= !w_win_a;
                        b_err   <= !w_win_a;
                        r_state <= RESP;
                    end else begin
                        stk_enable   <= 1'b1;
                        stk_push_pop <= w_op;
                        stk_data_in  <= w_data;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    a_ack   <= r_op && r_win_a;
                    b_ack   <= r_op && !r_win_a;
                    r_state <= r_op ? RESP : WAIT;
                end
                WAIT: begin
                    if (r_win_a) a_rdata <= stk_data_out;
                    else b_rdata <= stk_data_out;
                    a_ack   <= r_win_a;
                    b_ack   <= !r_win_a;
                    r_state <= RESP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed and randomized transactions against a queue-based
// model of the shared stack and round-robin grant order.
module tb_stack_arbiter;
    localparam int DW = 8;
    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, a_push_pop, a_ack, a_err;
    logic [DW-1:0] a_data, a_rdata;
    logic          b_req, b_push_pop, b_ack, b_err;
    logic [DW-1:0] b_data, b_rdata;
    logic          stk_enable, stk_push_pop, stk_empty, stk_full;
    logic [DW-1:0] stk_data_in;
    logic [DW-1:0] stk_data_out = '0;
    int            errors = 0;
    int            checks = 0;
    always #5 clk = ~clk;
    stack_arbiter #(.DW(DW)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_push_pop(a_push_pop), .a_data(a_data),
        .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_push_pop(b_push_pop), .b_data(b_data),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .stk_enable(stk_enable), .stk_push_pop(stk_push_pop), .stk_data_in(stk_data_in),
        .stk_data_out(stk_data_out), .stk_empty(stk_empty), .stk_full(stk_full)
    );
    // 8-entry stack datapath the arbiter drives
    logic [DW-1:0] mem [8];
    int            sp = 0;
    assign stk_empty = (sp == 0);
    assign stk_full  = (sp == 8);
    always @(posedge clk) begin
        if (stk_enable && stk_push_pop && sp < 8) begin
            mem[sp] <= stk_data_in;
            sp      <= sp + 1;
        end else if (stk_enable && !stk_push_pop && sp > 0) begin
            stk_data_out <= mem[sp-1];
            sp           <= sp - 1;
        end
    end
    // reference model
    logic [DW-1:0] q[$];
    bit            m_last_a;
    logic [DW-1:0] m_rd_a, m_rd_b;
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    function automatic logic [31:0] outs();
        return {2'b0, a_ack, a_err, a_rdata, b_ack, b_err, b_rdata, stk_enable, stk_push_pop, stk_data_in};
    endfunction
    task automatic do_reset();
        reset = 1'b1;
        a_req = 1'b0; a_push_pop = 1'b0; a_data = '0;
        b_req = 1'b0; b_push_pop = 1'b0; b_data = '0;
        #1;
        chk("reset_outs", outs(), 0);
        m_last_a = 1'b0; m_rd_a = '0; m_rd_b = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask
    // starts at a negedge with the DUT idle and requests already driven
    task automatic run_txn(output bit win_a);
        bit            op, err;
        logic [DW-1:0] d, v;
        int            lat, n_en, got;
        n_en  = 0;
        got   = 0;
        win_a = a_req && (!b_req || !m_last_a);
        op    = win_a ? a_push_pop : b_push_pop;
        d     = win_a ? a_data : b_data;
        err   = op ? (q.size() == 8) : (q.size() == 0);
        lat   = err ? 1 : (op ? 2 : 3);
        m_last_a = win_a;
        if (!err && op) q.push_back(d);
        if (!err && !op) begin
            v = q.pop_back();
            if (win_a) m_rd_a = v; else m_rd_b = v;
        end
        for (int n = 1; n <= 6 && got == 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            chk("loser_ack", win_a ? b_ack : a_ack, 0);
            if (stk_enable) begin
                n_en++;
                chk("en_cycle", n, 1);
                chk("en_op", stk_push_pop, op);
                if (op) chk("en_data", stk_data_in, d);
            end
            if (win_a ? a_ack : b_ack) begin
                got = n;
                chk("err", win_a ? a_err : b_err, err);
                chk("rdata_a", a_rdata, m_rd_a);
                chk("rdata_b", b_rdata, m_rd_b);
            end
        end
        chk("ack_latency", got, lat);
        chk("enables", n_en, err ? 0 : 1);
        @(negedge clk);
    endtask
    task automatic do_op(input bit is_a, input bit op, input logic [DW-1:0] d);
        bit w;
        if (is_a) begin a_req = 1'b1; a_push_pop = op; a_data = d; end
        else begin b_req = 1'b1; b_push_pop = op; b_data = d; end
        run_txn(w);
        a_req = 1'b0;
        b_req = 1'b0;
    endtask
    initial begin
        bit w;
        do_reset();
        do_op(1'b0, 1'b0, 8'h00);
        do_op(1'b1, 1'b1, 8'h11);
        do_op(1'b0, 1'b0, 8'h00);
        do_op(1'b1, 1'b1, 8'hAA);
        do_op(1'b0, 1'b0, 8'h00);
        // both clients hold pushes: grants must alternate
        a_req = 1'b1; a_push_pop = 1'b1; a_data = 8'hA0;
        b_req = 1'b1; b_push_pop = 1'b1; b_data = 8'hB0;
        for (int i = 0; i < 4; i++) begin
            run_txn(w);
            chk("tie_winner", w, (i % 2) == 0);
            if (w) a_data = a_data + 1; else b_data = b_data + 1;
        end
        a_req = 1'b0; b_req = 1'b0;
        for (int i = 0; i < 4; i++) do_op(1'b1, 1'b0, 8'h00);
        for (int i = 1; i <= 9; i++) do_op(1'b1, 1'b1, 8'(i));
        for (int i = 0; i < 9; i++) do_op(i % 2 == 0, 1'b0, 8'h00);
        // reset while a pop sits in WAIT
        do_op(1'b1, 1'b1, 8'h55);
        do_op(1'b1, 1'b1, 8'h66);
        do_op(1'b1, 1'b0, 8'h00);
        a_req = 1'b1; a_push_pop = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        void'(q.pop_back());
        do_reset();
        do_op(1'b1, 1'b1, 8'h77);
        for (int t = 0; t < 300; t++) begin
            if (!a_req && $urandom_range(0, 2) != 0) begin
                a_req = 1'b1; a_push_pop = ($urandom_range(0, 9) < 6); a_data = 8'($urandom);
            end
            if (!b_req && $urandom_range(0, 2) != 0) begin
                b_req = 1'b1; b_push_pop = ($urandom_range(0, 9) < 6); b_data = 8'($urandom);
            end
            if (!a_req && !b_req) begin
                @(posedge clk);
                @(negedge clk);
                chk("idle_quiet", {a_ack, b_ack, stk_enable}, 0);
            end else begin
                run_txn(w);
                if (w) a_req = ($urandom_range(0, 1) == 1); else b_req = ($urandom_range(0, 1) == 1);
                if (w && a_req) begin a_push_pop = ($urandom_range(0, 9) < 6); a_data = 8'($urandom); end
                if (!w && b_req) begin b_push_pop = ($urandom_range(0, 9) < 6); b_data = 8'($urandom); end
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
